// File: rtl/udp_pkg.sv
// udp_pkg: constants and types shared by the UDP transmit path
// (frame builder, sequencer and TX MAC).
package udp_pkg;

   localparam logic [15:0] C_ETHERTYPE_IPV4 = 16'h0800;
   localparam logic [7:0]  C_IP_PROTO_UDP   = 8'd17;

   localparam int C_ETH_HDR_LEN   = 14;
   localparam int C_IP_HDR_LEN    = 20;
   localparam int C_UDP_HDR_LEN   = 8;
   localparam int C_MIN_FRAME_LEN = 60;

   localparam logic [47:0] C_DEF_DST_MAC  = 48'hFFFF_FFFF_FFFF;
   localparam logic [47:0] C_DEF_SRC_MAC  = 48'h0200_0000_0001;
   localparam logic [31:0] C_DEF_SRC_IP   = 32'hC0A8_010A;
   localparam logic [31:0] C_DEF_DST_IP   = 32'hC0A8_0164;
   localparam logic [15:0] C_DEF_SRC_PORT = 16'd5000;
   localparam logic [15:0] C_DEF_DST_PORT = 16'd5001;
   localparam logic [7:0]  C_DEF_TTL      = 8'd64;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CSUM,
      S_HDR,
      S_PAYLOAD,
      S_PAD,
      S_DONE
   } build_state_t;

endpackage

// File: rtl/ip_csum16.sv
// ip_csum16: serial ones-complement sum of 16-bit words.
// Result is folded and inverted, valid the cycle after the last word.
module ip_csum16 (
   input  logic        clk,
   input  logic        nrst,
   input  logic        i_clr,
   input  logic        i_acc,
   input  logic [15:0] i_word,
   output logic [15:0] o_csum
);

   logic [19:0] r_sum;
   logic [16:0] w_f1;
   logic [15:0] w_f2;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_sum <= '0;
      end else if (i_clr) begin
         r_sum <= '0;
      end else if (i_acc) begin
         r_sum <= r_sum + 20'(i_word);
      end
   end

   // Two folds suffice: ten words never exceed 20 bits.
   assign w_f1   = 17'(r_sum[15:0]) + 17'(r_sum[19:16]);
   assign w_f2   = w_f1[15:0] + 16'(w_f1[16]);
   assign o_csum = ~w_f2;

endmodule

// File: rtl/udp_pkt_builder.sv
// udp_pkt_builder: writes one Ethernet II / IPv4 / UDP frame (no FCS)
// into the TX frame buffer per start pulse.
module udp_pkt_builder
   import udp_pkg::*;
#(
   parameter logic [47:0] P_DST_MAC  = C_DEF_DST_MAC,
   parameter logic [47:0] P_SRC_MAC  = C_DEF_SRC_MAC,
   parameter logic [31:0] P_SRC_IP   = C_DEF_SRC_IP,
   parameter logic [31:0] P_DST_IP   = C_DEF_DST_IP,
   parameter logic [15:0] P_SRC_PORT = C_DEF_SRC_PORT,
   parameter logic [15:0] P_DST_PORT = C_DEF_DST_PORT,
   parameter logic [7:0]  P_TTL      = C_DEF_TTL,
   parameter logic [7:0]  P_PL_LEN   = 8'd16
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic        i_pkt_start,
   output logic        o_pkt_end,
   output logic        o_busy,
   output logic [7:0]  o_pl_addr,
   input  logic [7:0]  i_pl_data,
   output logic        o_wr_en,
   output logic [10:0] o_wr_addr,
   output logic [7:0]  o_wr_data,
   output logic [10:0] o_pkt_len
);

   localparam int C_HDR = C_ETH_HDR_LEN + C_IP_HDR_LEN + C_UDP_HDR_LEN;
   localparam int C_END = C_HDR + int'(P_PL_LEN);
   localparam int C_LEN = (C_END < C_MIN_FRAME_LEN) ? C_MIN_FRAME_LEN : C_END;
   localparam logic [15:0] C_IP_TLEN =
      16'(C_IP_HDR_LEN + C_UDP_HDR_LEN + int'(P_PL_LEN));
   localparam logic [15:0] C_UDP_LEN = 16'(C_UDP_HDR_LEN + int'(P_PL_LEN));
   localparam build_state_t C_PL_NEXT =
      (C_END < C_MIN_FRAME_LEN) ? S_PAD : S_DONE;

   build_state_t r_st;
   logic [5:0]   r_cnt;
   logic [7:0]   r_pcnt;
   logic [15:0]  r_id;
   logic [15:0]  r_id_lat;

   logic         w_clr;
   logic         w_acc;
   logic [15:0]  w_word;
   logic [15:0]  w_csum;
   logic [159:0] w_ipw;
   logic [335:0] w_hdr;
   logic [5:0]   w_hsel;
   logic [7:0]   w_hbyte;

   assign w_ipw = {8'h45, 8'h00, C_IP_TLEN, r_id_lat, 16'h4000,
                   P_TTL, C_IP_PROTO_UDP, 16'h0000, P_SRC_IP, P_DST_IP};

   assign w_hdr = {P_DST_MAC, P_SRC_MAC, C_ETHERTYPE_IPV4,
                   8'h45, 8'h00, C_IP_TLEN, r_id_lat, 16'h4000,
                   P_TTL, C_IP_PROTO_UDP, w_csum, P_SRC_IP, P_DST_IP,
                   P_SRC_PORT, P_DST_PORT, C_UDP_LEN, 16'h0000};

   assign w_clr  = (r_st == S_IDLE) && i_pkt_start && !o_pkt_end;
   assign w_acc  = (r_st == S_CSUM);
   assign w_hsel = (r_st == S_HDR) ? r_cnt + 6'd1 : 6'd0;

   always_comb begin
      w_word = '0;
      for (int i = 0; i < 10; i++) begin
         if (r_cnt[3:0] == 4'(i)) w_word = w_ipw[16*(9-i) +: 16];
      end
   end

   always_comb begin
      w_hbyte = '0;
      for (int i = 0; i < C_HDR; i++) begin
         if (w_hsel == 6'(i)) w_hbyte = w_hdr[8*(C_HDR-1-i) +: 8];
      end
   end

   ip_csum16 u_csum (
      .clk    (clk),
      .nrst   (nrst),
      .i_clr  (w_clr),
      .i_acc  (w_acc),
      .i_word (w_word),
      .o_csum (w_csum)
   );

   // Payload address runs one cycle ahead so the buffer's read
   // latency is hidden and the byte can be written from a register.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_st      <= S_IDLE;
         r_cnt     <= '0;
         r_pcnt    <= '0;
         r_id      <= '0;
         r_id_lat  <= '0;
         o_pkt_end <= 1'b0;
         o_busy    <= 1'b0;
         o_pl_addr <= '0;
         o_wr_en   <= 1'b0;
         o_wr_addr <= '0;
         o_wr_data <= '0;
         o_pkt_len <= '0;
      end else begin
         o_pkt_end <= 1'b0;
         o_wr_en   <= 1'b0;
         unique case (r_st)
            S_IDLE: begin
               if (w_clr) begin
                  r_st     <= S_CSUM;
                  r_cnt    <= '0;
                  r_id_lat <= r_id;
                  o_busy   <= 1'b1;
               end
            end
            S_CSUM: begin
               if (r_cnt == 6'd9) begin
                  r_st      <= S_HDR;
                  r_cnt     <= '0;
                  o_wr_en   <= 1'b1;
                  o_wr_addr <= '0;
                  o_wr_data <= w_hbyte;
               end else begin
                  r_cnt <= r_cnt + 6'd1;
               end
            end
            S_HDR: begin
               if (r_cnt == 6'(C_HDR - 2)) o_pl_addr <= '0;
               if (r_cnt == 6'(C_HDR - 1)) begin
                  r_st      <= S_PAYLOAD;
                  r_pcnt    <= '0;
                  o_pl_addr <= (P_PL_LEN > 8'd1) ? 8'd1 : 8'd0;
               end else begin
                  r_cnt     <= r_cnt + 6'd1;
                  o_wr_en   <= 1'b1;
                  o_wr_addr <= o_wr_addr + 11'd1;
                  o_wr_data <= w_hbyte;
               end
            end
            S_PAYLOAD: begin
               o_wr_en   <= 1'b1;
               o_wr_addr <= 11'(C_HDR) + 11'(r_pcnt);
               o_wr_data <= i_pl_data;
               if (9'(r_pcnt) + 9'd2 < 9'(P_PL_LEN))
                  o_pl_addr <= r_pcnt + 8'd2;
               if (r_pcnt == P_PL_LEN - 8'd1) r_st <= C_PL_NEXT;
               else r_pcnt <= r_pcnt + 8'd1;
            end
            S_PAD: begin
               o_wr_en   <= 1'b1;
               o_wr_addr <= o_wr_addr + 11'd1;
               o_wr_data <= 8'h00;
               if (o_wr_addr == 11'(C_LEN - 2)) r_st <= S_DONE;
            end
            S_DONE: begin
               r_st      <= S_IDLE;
               o_pkt_end <= 1'b1;
               o_busy    <= 1'b0;
               o_pkt_len <= 11'(C_LEN);
               r_id      <= r_id + 16'd1;
            end
            default: r_st <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_udp_pkt_builder.sv
// tb_udp_pkt_builder: randomized builds on two builder instances
// (16- and 64-byte payloads) checked against a byte-level frame model.
module tb_udp_pkt_builder;

   logic clk = 1'b0;
   logic nrst;
   always #4 clk = ~clk;

   logic        start   [2];
   logic        pkt_end [2];
   logic        busy    [2];
   logic        wr_en   [2];
   logic [7:0]  pl_addr [2];
   logic [7:0]  pl_data [2];
   logic [7:0]  wr_data [2];
   logic [10:0] wr_addr [2];
   logic [10:0] pkt_len [2];

   logic [7:0]  mem  [2][256];
   logic [7:0]  cap  [2][2048];
   int          wcnt [2][2048];
   int          stray [2];
   int          ends  [2];
   int          plq   [2][$];
   logic [7:0]  exp_f [2048];
   int          exp_len;
   logic [15:0] exp_id [2];

   int n_tests = 0;
   int n_fail  = 0;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      udp_pkt_builder #(
         .P_PL_LEN ((g == 0) ? 8'd16 : 8'd64)
      ) u_dut (
         .clk         (clk),
         .nrst        (nrst),
         .i_pkt_start (start[g]),
         .o_pkt_end   (pkt_end[g]),
         .o_busy      (busy[g]),
         .o_pl_addr   (pl_addr[g]),
         .i_pl_data   (pl_data[g]),
         .o_wr_en     (wr_en[g]),
         .o_wr_addr   (wr_addr[g]),
         .o_wr_data   (wr_data[g]),
         .o_pkt_len   (pkt_len[g])
      );
   end

   // Synchronous payload RAM: data one clock after the address.
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) pl_data[i] <= mem[i][pl_addr[i]];
   end

   always @(negedge clk) begin
      if (nrst) begin
         for (int i = 0; i < 2; i++) begin
            if (wr_en[i]) begin
               cap[i][wr_addr[i]] = wr_data[i];
               wcnt[i][wr_addr[i]]++;
               if (!busy[i]) stray[i]++;
            end
            if (pkt_end[i]) ends[i]++;
            if (busy[i] && (plq[i].size() == 0 ||
                plq[i][$] != int'(pl_addr[i])))
               plq[i].push_back(int'(pl_addr[i]));
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int pl_of(input int i);
      return (i == 0) ? 16 : 64;
   endfunction

   function automatic void put(input int a, input logic [47:0] v,
                               input int n);
      for (int k = 0; k < n; k++) exp_f[a+k] = v[8*(n-1-k) +: 8];
   endfunction

   task automatic build_exp(input int i, input logic [15:0] id);
      int L;
      int s;
      L = pl_of(i);
      for (int a = 0; a < 2048; a++) exp_f[a] = 8'h00;
      put(0, 48'hFFFF_FFFF_FFFF, 6);
      put(6, 48'h0200_0000_0001, 6);
      put(12, 48'h0800, 2);
      put(14, 48'h45, 1);
      put(15, 48'h00, 1);
      put(16, 48'(28 + L), 2);
      put(18, 48'(id), 2);
      put(20, 48'h4000, 2);
      put(22, 48'd64, 1);
      put(23, 48'd17, 1);
      put(24, 48'h0, 2);
      put(26, 48'hC0A8_010A, 4);
      put(30, 48'hC0A8_0164, 4);
      s = 0;
      for (int k = 0; k < 10; k++)
         s += int'({exp_f[14+2*k], exp_f[15+2*k]});
      while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
      put(24, 48'(16'(~s)), 2);
      put(34, 48'd5000, 2);
      put(36, 48'd5001, 2);
      put(38, 48'(8 + L), 2);
      put(40, 48'h0, 2);
      for (int k = 0; k < L; k++) exp_f[42+k] = mem[i][k];
      exp_len = (42 + L < 60) ? 60 : 42 + L;
   endtask

   task automatic run_build(input int i, input bit ramp, input bit junk,
                            input int abort_at);
      int L, endc, busy_bad, post_busy, nbad, nw, wb, last, rj;
      bit ok;
      L = pl_of(i);
      endc = 0; busy_bad = 0; post_busy = 0;
      nbad = 0; nw = 0; wb = 0; last = -1;
      for (int k = 0; k < 256; k++)
         mem[i][k] = ramp ? 8'(k) : 8'($urandom);
      for (int a = 0; a < 2048; a++) wcnt[i][a] = 0;
      stray[i] = 0;
      ends[i] = 0;
      plq[i].delete();
      build_exp(i, exp_id[i]);
      rj = $urandom_range(1, 11 + exp_len);
      @(negedge clk);
      start[i] = 1'b1;
      for (int c = 1; c <= 400; c++) begin
         @(negedge clk);
         if (abort_at != 0 && c == abort_at) begin
            start[i] = 1'b0;
            nrst = 1'b0;
            #1;
            for (int j = 0; j < 2; j++)
               chk("rst_outs", 64'({pkt_end[j], busy[j], wr_en[j],
                   wr_addr[j], wr_data[j], pl_addr[j], pkt_len[j]}), 64'(0));
            repeat (3) @(negedge clk);
            nrst = 1'b1;
            repeat (3) @(negedge clk);
            chk("rst_no_end", 64'(ends[i]), 64'(0));
            exp_id[0] = 16'h0;
            exp_id[1] = 16'h0;
            return;
         end
         if (pkt_end[i]) begin
            endc = c;
            start[i] = junk;
            break;
         end
         if (!busy[i]) busy_bad++;
         start[i] = junk && (c == 5 || c == 40 || c == 71 || c == rj);
      end
      chk("end_cycle", 64'(endc), 64'(12 + exp_len));
      @(negedge clk);
      start[i] = 1'b0;
      repeat (4) begin
         if (busy[i]) post_busy++;
         @(negedge clk);
      end
      #1;
      for (int a = 0; a < 2048; a++) begin
         nw += wcnt[i][a];
         if (wcnt[i][a] != 0) last = a;
         if (a < exp_len) begin
            if (wcnt[i][a] != 1) wb++;
            if (cap[i][a] !== exp_f[a]) nbad++;
         end
      end
      chk("busy_hold", 64'(busy_bad), 64'(0));
      chk("busy_after", 64'(post_busy), 64'(0));
      chk("end_count", 64'(ends[i]), 64'(1));
      chk("n_writes", 64'(nw), 64'(exp_len));
      chk("addr_once", 64'(wb), 64'(0));
      chk("frame_bytes", 64'(nbad), 64'(0));
      chk("last_addr", 64'(last), 64'(exp_len - 1));
      chk("stray_wr", 64'(stray[i]), 64'(0));
      chk("pkt_len", 64'(pkt_len[i]), 64'(exp_len));
      if (plq[i].size() > 0 && plq[i][0] != 0) void'(plq[i].pop_front());
      ok = (plq[i].size() == L);
      for (int k = 0; k < plq[i].size(); k++) if (plq[i][k] != k) ok = 1'b0;
      chk("pl_addr_seq", 64'(ok), 64'(1));
      exp_id[i] = exp_id[i] + 16'd1;
   endtask

   initial begin
      nrst = 1'b0;
      start[0] = 1'b0;
      start[1] = 1'b0;
      exp_id[0] = 16'h0;
      exp_id[1] = 16'h0;
      repeat (3) @(negedge clk);
      for (int j = 0; j < 2; j++)
         chk("reset_outs", 64'({pkt_end[j], busy[j], wr_en[j], wr_addr[j],
             wr_data[j], pl_addr[j], pkt_len[j]}), 64'(0));
      nrst = 1'b1;
      repeat (2) @(negedge clk);

      run_build(0, 1'b1, 1'b0, 0);
      chk("ip_tlen", 64'({cap[0][16], cap[0][17]}), 64'(16'h002C));
      chk("ip_csum0", 64'({cap[0][24], cap[0][25]}), 64'(16'hB702));
      chk("udp_len", 64'({cap[0][38], cap[0][39]}), 64'(16'h0018));
      chk("pl_last", 64'(cap[0][57]), 64'(8'h0F));
      chk("pad", 64'({cap[0][58], cap[0][59]}), 64'(16'h0000));

      run_build(0, 1'b0, 1'b0, 0);
      chk("ip_id1", 64'({cap[0][18], cap[0][19]}), 64'(16'h0001));
      chk("ip_csum1", 64'({cap[0][24], cap[0][25]}), 64'(16'hB701));

      run_build(0, 1'b0, 1'b1, 0);

      run_build(1, 1'b0, 1'b0, 0);
      chk("len64", 64'(pkt_len[1]), 64'(106));
      chk("tlen64", 64'({cap[1][16], cap[1][17]}), 64'(16'h005C));
      chk("ulen64", 64'({cap[1][38], cap[1][39]}), 64'(16'h0048));

      repeat (6) run_build($urandom_range(0, 1), 1'b0,
                           1'($urandom_range(0, 1)), 0);

      run_build(0, 1'b0, 1'b0, 50);
      run_build(0, 1'b0, 1'b0, 0);
      chk("id_after_rst", 64'({cap[0][18], cap[0][19]}), 64'(16'h0000));
      run_build(1, 1'b0, 1'b1, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
